sa_ctrl: RTL and testbench

Sequencing controller for the output-stationary systolic array built from `pe`/`mac` tiles. For each job it:
- clears the accumulators;
- issues operand-fetch indices to the edge operand buffers;
- drives the per-PE `acc_en` wavefront, matched to the skew of operands marching through `data_a`/`data_b`;
- drains the result rows through a valid/ready handshake.

It sits between the FFN layer sequencer (start/done) and the PE grid plus its operand buffers.

---
 rtl/sa_ctrl.sv | 69 ++++++
 tb/tb_sa_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sa_ctrl.sv
// sa_ctrl: job sequencer for an output-stationary systolic array (clear, feed, acc_en wavefront, row drain)
module sa_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_WIDTH   = 16,
  parameter int FETCH_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [K_WIDTH-1:0]      k_len_i,
  output logic                    busy_o,
  output logic                    clear_o,
  output logic                    feed_valid_o,
  output logic [K_WIDTH-1:0]      feed_idx_o,
  output logic [ROWS*COLS-1:0]    acc_en_o,
  output logic                    drain_valid_o,
  output logic [$clog2(ROWS)-1:0] drain_row_o,
  input  logic                    drain_ready_i,
  output logic                    done_o
);
  localparam int TW = K_WIDTH + $clog2(ROWS + COLS + FETCH_LAT) + 1;
  localparam int RW = $clog2(ROWS);
  typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] t, t_last;
  logic [K_WIDTH-1:0] k_lat;
  logic [RW-1:0] row;
  logic feeding;
  assign t_last = TW'(k_lat) + TW'(FETCH_LAT + ROWS + COLS - 3);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (start_i && k_len_i != '0) ? CLEAR : IDLE;
      CLEAR:   state_n = COMPUTE;
      COMPUTE: state_n = (t == t_last) ? DRAIN : COMPUTE;
      DRAIN:   state_n = (drain_ready_i && row == RW'(ROWS - 1)) ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      k_lat <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      t     <= (state == COMPUTE) ? t + 1'b1 : '0;
      if (state == IDLE && state_n == CLEAR) k_lat <= k_len_i;
      if (state == DRAIN && drain_ready_i) row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
    end
  end
  assign feeding       = state == COMPUTE && t < TW'(k_lat);
  assign busy_o        = state != IDLE;
  assign clear_o       = state == CLEAR;
  assign feed_valid_o  = feeding;
  assign feed_idx_o    = feeding ? t[K_WIDTH-1:0] : '0;
  assign drain_valid_o = state == DRAIN;
  assign drain_row_o   = row;
  assign done_o        = state == DONE;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int OFF = FETCH_LAT + r + c;
      assign acc_en_o[r*COLS+c] = state == COMPUTE && t >= TW'(OFF) && (t - TW'(OFF)) < TW'(k_lat);
    end
  end
endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: randomized and directed checks of sa_ctrl against a cycle-indexed job model
module tb_sa_ctrl;
  localparam int R = 4, C = 4, KW = 8, FL = 1;
  localparam int OW = 3 + KW + R * C + 1 + 2 + 1;
  logic clk, rst, start, drain_ready;
  logic [KW-1:0] k_len;
  logic busy, clear, feed_valid, drain_valid, done;
  logic [KW-1:0] feed_idx;
  logic [R*C-1:0] acc_en;
  logic [1:0] drain_row;
  logic [OW-1:0] outs;
  int tests = 0, fails = 0;
  sa_ctrl #(.ROWS(R), .COLS(C), .K_WIDTH(KW), .FETCH_LAT(FL)) dut (
    .clk(clk), .rst(rst), .start_i(start), .k_len_i(k_len), .busy_o(busy), .clear_o(clear),
    .feed_valid_o(feed_valid), .feed_idx_o(feed_idx), .acc_en_o(acc_en),
    .drain_valid_o(drain_valid), .drain_row_o(drain_row), .drain_ready_i(drain_ready), .done_o(done)
  );
  assign outs = {busy, clear, feed_valid, feed_idx, acc_en, drain_valid, drain_row, done};
  always #5 clk = ~clk;
  // n = cycles since the start cycle, x = rows already accepted downstream
  function automatic logic [OW-1:0] model(input int k, input int n, input int x);
    int tl, t;
    logic b, cl, fv, dv, dn;
    logic [KW-1:0] idx;
    logic [R*C-1:0] ae;
    logic [1:0] row;
    tl = k + FL + R + C - 2;
    {b, cl, fv, dv, dn} = '0;
    idx = '0; ae = '0; row = '0;
    if (n == 1) begin
      b = 1; cl = 1;
    end else if (n >= 2 && n < 2 + tl) begin
      t = n - 2; b = 1; fv = t < k;
      idx = fv ? KW'(t) : '0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          ae[r*C+c] = (t - FL - r - c >= 0) && (t - FL - r - c < k);
    end else if (n >= 2 + tl) begin
      b = 1;
      if (x < R) begin dv = 1; row = 2'(x); end else dn = 1;
    end
    return {b, cl, fv, idx, ae, dv, row, dn};
  endfunction
  // mode: 0 ready high, 1 five-cycle stall at row 2, 2 random ready, 3 extra start at n=5, 4 start held high
  task automatic test_job(input string nm, input int k, input int mode, input int rst_at,
                          output int done_n, output int max_idx, output int f33, output int l33);
    int x = 0, st = 0, tl = k + FL + R + C - 2;
    logic [OW-1:0] o, e;
    logic rdy;
    done_n = -1; max_idx = -1; f33 = -1; l33 = -1;
    for (int n = 0; n < tl + 200; n++) begin
      start = (mode == 4) || n == 0 || (mode == 3 && n == 5);
      k_len = (mode == 3 && n == 5) ? KW'(k + 4) : KW'(k);
      rdy = (mode == 1) ? !(x == 2 && st < 5) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      drain_ready = rdy;
      rst = (n == rst_at);
      @(negedge clk);
      o = outs;
      e = model(k, n, x);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s n=%0d got %h exp %h", nm, n, o, e);
      end
      if (feed_valid && int'(feed_idx) > max_idx) max_idx = int'(feed_idx);
      if (acc_en[R*C-1]) begin
        if (f33 < 0) f33 = n - 2;
        l33 = n - 2;
      end
      if (e[3] && !rdy && x == 2) st++;
      if (e[3] && rdy) x++;
      @(posedge clk); #1;
      start = 0; rst = 0;
      if (n == rst_at) begin
        @(negedge clk);
        tests++;
        if (outs !== '0) begin
          fails++;
          $display("FAIL %s_after_rst got %h exp 0", nm, outs);
        end
        @(posedge clk); #1;
        return;
      end
      if (e[0]) begin
        done_n = n;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL %s timeout got no done_o exp done", nm);
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_hold got %h exp 0", outs); end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_release got %h exp 0", outs); end
    @(posedge clk); #1;
  endtask
  task automatic test_basic();
    int d, mi, f, l;
    test_job("basic", 3, 0, -1, d, mi, f, l);
    tests++;
    if (d != 16 || mi != 2 || f != 7 || l != 9) begin
      fails++;
      $display("FAIL basic_timing got done=%0d idx=%0d pe33=%0d..%0d exp 16 2 7..9", d, mi, f, l);
    end
  endtask
  task automatic test_backpressure();
    int d, mi, f, l;
    test_job("backpressure", 3, 1, -1, d, mi, f, l);
    tests++;
    if (d != 21) begin fails++; $display("FAIL backpressure_done got %0d exp 21", d); end
  endtask
  task automatic test_ignored_starts();
    int d, mi, f, l;
    start = 1; k_len = '0;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (outs !== '0) begin fails++; $display("FAIL k0_start cyc=%0d got %h exp 0", i, outs); end
      @(posedge clk); #1;
    end
    test_job("start_busy", 3, 3, -1, d, mi, f, l);
    tests++;
    if (d != 16) begin fails++; $display("FAIL start_busy_done got %0d exp 16", d); end
  endtask
  task automatic test_reset_mid();
    int d, mi, f, l;
    test_job("rst_mid", 3, 0, 7, d, mi, f, l);
    tests++;
    if (d != -1) begin fails++; $display("FAIL rst_mid_done got %0d exp none", d); end
    test_job("after_rst", 2, 0, -1, d, mi, f, l);
    tests++;
    if (d != 15) begin fails++; $display("FAIL after_rst_done got %0d exp 15", d); end
  endtask
  task automatic test_long_k();
    int d, mi, f, l;
    test_job("long_k", 255, 0, -1, d, mi, f, l);
    tests++;
    if (d != 268 || mi != 254 || f != 7 || l != 261) begin
      fails++;
      $display("FAIL long_k got done=%0d idx=%0d pe33=%0d..%0d exp 268 254 7..261", d, mi, f, l);
    end
  endtask
  task automatic test_back_to_back();
    int d, mi, f, l;
    for (int j = 0; j < 3; j++) begin
      test_job("b2b", 1, 4, -1, d, mi, f, l);
      tests++;
      if (d != 14) begin fails++; $display("FAIL b2b_done job=%0d got %0d exp 14", j, d); end
    end
    start = 0;
  endtask
  task automatic test_random();
    int d, mi, f, l;
    for (int j = 0; j < 8; j++)
      test_job("random", int'($urandom_range(1, 20)), (j % 3 == 2) ? 3 : 2, -1, d, mi, f, l);
  endtask
  initial begin
    clk = 0; rst = 1; start = 0; k_len = '0; drain_ready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_starts();
    test_reset_mid();
    test_long_k();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
